// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared defaults, FSM state type and a counter-width helper
//                for the I2S audio transmit path.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

  localparam int SAMPLE_W_DEF    = 16;
  localparam int CLK_DIV_DEF     = 16;
  localparam int INIT_CYCLES_DEF = 1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } tx_state_t;

  // Width of a counter that must hold the values 0..n-1 (never less than 1 bit)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_bclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : audio_bclk_gen
//  Description : I2S bit-clock divider. While enabled, BCLK toggles every
//                CLK_DIV system clocks; o_fall_stb flags the clock cycle whose
//                closing edge drives BCLK from 1 to 0. Disabled = held at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_bclk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_bclk,
  output logic o_fall_stb
);

  localparam int               DIV_W      = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             w_wrap;

  // Half-period divider; counter and BCLK restart from zero whenever disabled
  always_comb begin
    w_wrap    = i_en && (div_cnt_q == C_DIV_LAST);
    div_cnt_d = '0;
    bclk_d    = 1'b0;
    if (i_en) begin
      div_cnt_d = w_wrap ? '0 : div_cnt_q + DIV_W'(1);
      bclk_d    = w_wrap ? ~bclk_q : bclk_q;
    end
  end

  // Divider state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign o_bclk     = bclk_q;
  assign o_fall_stb = w_wrap && bclk_q;

endmodule
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_tx
//  Description : I2S transmitter. Runs the Init/Init_Finish start-up wait,
//                then serialises {LDATA,RDATA} MSB first with the standard
//                one-bit I2S delay and pulses data_over once per frame when
//                a new sample pair has been captured.
//                Build option: define MONO_MIX_EN to transmit the average of
//                the two channels on both slots instead of stereo data.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [SAMPLE_W-1:0] LDATA,
  input  logic [SAMPLE_W-1:0] RDATA,
  input  logic                Init,
  output logic                Init_Finish,
  output logic                data_over,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                DACDAT
);

  localparam int                FRAME_W      = 2 * SAMPLE_W;
  localparam int                SLOT_W       = cnt_width(FRAME_W);
  localparam int                INIT_W       = cnt_width(INIT_CYCLES);
  localparam logic [INIT_W-1:0] C_INIT_LAST  = INIT_W'(INIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] C_SLOT_LAST  = SLOT_W'(FRAME_W - 1);
  localparam logic [SLOT_W-1:0] C_SLOT_FIRST = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] C_SLOT_RIGHT = SLOT_W'(SAMPLE_W);

  tx_state_t          state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic               init_finish_q, init_finish_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               lrclk_q, lrclk_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               data_over_q, data_over_d;

  logic               w_run;
  logic               w_bclk;
  logic               w_fall_stb;
  logic [SLOT_W-1:0]  w_slot_next;
  logic [FRAME_W-1:0] w_word;

`ifdef MONO_MIX_EN
  // 17-bit signed sum cannot overflow; >>> floors toward minus infinity
  logic signed [SAMPLE_W:0]   w_sum;
  logic        [SAMPLE_W-1:0] w_mono;
  assign w_sum  = $signed({LDATA[SAMPLE_W-1], LDATA}) + $signed({RDATA[SAMPLE_W-1], RDATA});
  assign w_mono = SAMPLE_W'(w_sum >>> 1);
  assign w_word = {w_mono, w_mono};
`else
  assign w_word = {LDATA, RDATA};
`endif

  assign w_run = (state_q == RUN);

  audio_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk        (Clk),
    .rst        (Reset),
    .i_en       (w_run),
    .o_bclk     (w_bclk),
    .o_fall_stb (w_fall_stb)
  );

  // Next-state logic: start-up FSM plus slot/shift updates on each BCLK fall
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    slot_d      = slot_q;
    lrclk_d     = lrclk_q;
    shift_d     = shift_q;
    data_over_d = 1'b0;
    w_slot_next = (slot_q == C_SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (Init) begin
          state_d    = WAIT;
          init_cnt_d = '0;
        end
      end
      WAIT: begin
        // Init is not looked at here: the request was latched on entry
        if (init_cnt_q == C_INIT_LAST) begin
          state_d = RUN;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // RUN only leaves through Reset, so this is sticky once set
    init_finish_d = (state_d == RUN);

    // Slot 0 shifts out R[0] of the previous word; the capture entering slot 1
    // therefore realises the one-bit I2S delay without extra storage
    if (w_fall_stb) begin
      slot_d  = w_slot_next;
      lrclk_d = (w_slot_next >= C_SLOT_RIGHT);
      if (w_slot_next == C_SLOT_FIRST) begin
        shift_d     = w_word;
        data_over_d = 1'b1;
      end else begin
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
      end
    end
  end

  // State and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      init_cnt_q    <= '0;
      init_finish_q <= 1'b0;
      slot_q        <= '0;
      lrclk_q       <= 1'b0;
      shift_q       <= '0;
      data_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      init_finish_q <= init_finish_d;
      slot_q        <= slot_d;
      lrclk_q       <= lrclk_d;
      shift_q       <= shift_d;
      data_over_q   <= data_over_d;
    end
  end

  assign Init_Finish = init_finish_q;
  assign data_over   = data_over_q;
  assign BCLK        = w_bclk;
  assign LRCLK       = lrclk_q;
  assign DACDAT      = shift_q[FRAME_W-1];

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_i2s_tx
//  Description : Self-checking bench for audio_i2s_tx. One instance at
//                CLK_DIV=16, a second at CLK_DIV=2. Expected serial words come
//                from a hand-filled vector table (mono values when
//                MONO_MIX_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0]   l;
    logic [W-1:0]   r;
    logic [2*W-1:0] exp;
  } vec_t;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Init;
  logic         Init2;
  logic [W-1:0] LDATA;
  logic [W-1:0] RDATA;

  logic if1, dov1, bclk1, lr1, dac1;
  logic if2, dov2, bclk2, lr2, dac2;

  logic sel;
  logic m_if, m_dover, m_bclk, m_lr, m_dac;

  vec_t        vec[4];
  logic [31:0] exp_chg1;
  logic [31:0] exp_chg2;

  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc_cnt = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  audio_i2s_tx #(.SAMPLE_W(W), .CLK_DIV(16), .INIT_CYCLES(1000)) dut (
    .Clk(Clk), .Reset(Reset), .LDATA(LDATA), .RDATA(RDATA), .Init(Init),
    .Init_Finish(if1), .data_over(dov1), .BCLK(bclk1), .LRCLK(lr1), .DACDAT(dac1)
  );

  audio_i2s_tx #(.SAMPLE_W(W), .CLK_DIV(2), .INIT_CYCLES(1000)) dut2 (
    .Clk(Clk), .Reset(Reset), .LDATA(LDATA), .RDATA(RDATA), .Init(Init2),
    .Init_Finish(if2), .data_over(dov2), .BCLK(bclk2), .LRCLK(lr2), .DACDAT(dac2)
  );

  assign m_if    = sel ? if2   : if1;
  assign m_dover = sel ? dov2  : dov1;
  assign m_bclk  = sel ? bclk2 : bclk1;
  assign m_lr    = sel ? lr2   : lr1;
  assign m_dac   = sel ? dac2  : dac1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_rise(output int c);
    c = 0;
    while (m_bclk && c < 300) begin tick(); c++; end
    while (!m_bclk && c < 300) begin tick(); c++; end
    if (c >= 300) check("bclk_rise_timeout", m_bclk, 1'b1);
  endtask

  task automatic wait_dover();
    int   n = 0;
    logic prev;
    prev = m_bclk;
    while (!m_dover && n < 3000) begin
      prev = m_bclk;
      tick();
      n++;
    end
    check("dover_seen", m_dover, 1'b1);
    check("dover_on_bclk_fall", {prev, m_bclk}, 2'b10);
  endtask

  task automatic do_init(input int div);
    int zeros = 0;
    int bad   = 0;
    int c;
    if (sel) Init2 = 1'b1; else Init = 1'b1;
    tick();
    Init  = 1'b0;
    Init2 = 1'b0;
    while (!m_if && zeros < 1200) begin
      if (m_bclk || m_lr || m_dac || m_dover) bad++;
      zeros++;
      tick();
    end
    check("init_wait_len", zeros, 1000);
    check("wait_outputs_quiet", bad, 0);
    wait_rise(c);
    check("first_rise_delay", c, div);
    check("first_slot0_lr_dac", {m_lr, m_dac}, 2'b00);
  endtask

  // Collects slots 1..31 and the following slot 0 on BCLK rises
  task automatic collect_frame(input int div, output logic [31:0] data,
                               output logic [31:0] lr, output int bad_per);
    int c;
    bad_per = 0;
    for (int j = 0; j < 32; j++) begin
      wait_rise(c);
      if (j > 0 && c != 2 * div) bad_per++;
      data[31-j] = m_dac;
      lr[31-j]   = m_lr;
    end
  endtask

  task automatic run_vectors(input int div);
    int unsigned t_prev = 0;
    logic [31:0] data;
    logic [31:0] lr;
    int          bad_per;
    for (int i = 0; i < 4; i++) begin
      wait_dover();
      if (i > 0) check("frame_period", cyc_cnt - t_prev, 64 * div);
      t_prev = cyc_cnt;
      if (i < 3) begin
        LDATA = vec[i+1].l;
        RDATA = vec[i+1].r;
      end
      tick();
      check("dover_width", m_dover, 1'b0);
      collect_frame(div, data, lr, bad_per);
      check($sformatf("serial_word_%0d", i), data, vec[i].exp);
      check("lrclk_pattern", lr, 32'h0001_FFFE);
      check("bclk_period", bad_per, 0);
    end
    check("init_finish_sticky", m_if, 1'b1);
  endtask

  initial begin
    logic [31:0] data;
    logic [31:0] lr;
    int          bad_per;
    int          c;
    int          bad;

`ifdef MONO_MIX_EN
    vec[0] = '{16'hA5C3, 16'h3C5A, 32'hF10E_F10E};
    vec[1] = '{16'h7FFF, 16'h7FFF, 32'h7FFF_7FFF};
    vec[2] = '{16'h8000, 16'h0001, 32'hC000_C000};
    vec[3] = '{16'hFFFF, 16'h0000, 32'hFFFF_FFFF};
    exp_chg1 = 32'hF10E_F10E;
    exp_chg2 = 32'hDBFB_DBFB;
`else
    vec[0] = '{16'hA5C3, 16'h3C5A, 32'hA5C3_3C5A};
    vec[1] = '{16'h7FFF, 16'h7FFF, 32'h7FFF_7FFF};
    vec[2] = '{16'h8000, 16'h0001, 32'h8000_0001};
    vec[3] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
    exp_chg1 = 32'hA5C3_3C5A;
    exp_chg2 = 32'hA5C3_1234;
`endif

    sel   = 1'b0;
    Reset = 1'b1;
    Init  = 1'b0;
    Init2 = 1'b0;
    LDATA = vec[0].l;
    RDATA = vec[0].r;
    repeat (3) tick();
    check("reset_outputs", {if1, dov1, bclk1, lr1, dac1}, 5'b0);
    check("reset_outputs_div2", {if2, dov2, bclk2, lr2, dac2}, 5'b0);
    Reset = 1'b0;

    bad = 0;
    repeat (20) begin
      tick();
      if (m_if || m_bclk || m_lr || m_dac || m_dover) bad++;
    end
    check("idle_without_init", bad, 0);

    // Start-up and stereo/mono vector table at CLK_DIV=16
    do_init(16);
    run_vectors(16);

    // RDATA changed in the data_over cycle must only show in the next frame
    LDATA = 16'hA5C3;
    RDATA = 16'h3C5A;
    wait_dover();
    RDATA = 16'h1234;
    tick();
    collect_frame(16, data, lr, bad_per);
    check("late_change_current_frame", data, exp_chg1);
    wait_dover();
    tick();
    collect_frame(16, data, lr, bad_per);
    check("late_change_next_frame", data, exp_chg2);

    // Reset in slot 20, mid-cycle
    LDATA = vec[0].l;
    RDATA = vec[0].r;
    wait_dover();
    tick();
    for (int j = 0; j < 20; j++) wait_rise(c);
    check("slot20_lrclk_high", {m_if, m_bclk, m_lr}, 3'b111);
    #2 Reset = 1'b1;
    #1 check("async_reset_outputs", {if1, dov1, bclk1, lr1, dac1}, 5'b0);
    tick();
    Reset = 1'b0;
    bad = 0;
    repeat (100) begin
      tick();
      if (m_bclk || m_if || m_dover) bad++;
    end
    check("no_bclk_after_reset", bad, 0);
    do_init(16);
    wait_dover();
    tick();
    collect_frame(16, data, lr, bad_per);
    check("post_reset_word", data, vec[0].exp);

    // Same table with the fast divider
    sel   = 1'b1;
    LDATA = vec[0].l;
    RDATA = vec[0].r;
    do_init(2);
    run_vectors(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
